mtr_pwm_drv: RTL

- Motor PWM driver stage between the motion controller's signed speed outputs and the lftPWM1/2 and rghtPWM1/2 pins of KnightsTour.
- Converts each signed 11-bit speed command into a complementary PWM pair with dead time, so the H-bridge never has both legs on together.
- Duty is double-buffered and only updates at the period wrap, so a mid-period command change cannot produce a glitch pulse.
- These four pins are what KnightPhysics consumes.

---
 rtl/mtr_pwm_drv.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/mtr_pwm_drv.sv
// -----------------------------------------------------------------------------
// mtr_pwm_drv
//   Motor PWM driver stage. Turns the signed left/right speed commands into
//   complementary PWM pairs (lftPWM1/2, rghtPWM1/2) with dead time so the
//   H-bridge never has both legs on together.
//
//   - Free-running PWM_W-bit counter; period is 2^PWM_W clk.
//   - Duty = spd + 2^(PWM_W-1) (MSB of spd inverted), double-buffered and
//     loaded only in the cycle the counter sits at its top value.
//   - Raw PWM is a registered compare; each channel runs a FWD/REV/DEAD_T
//     non-overlap FSM that inserts DEAD low cycles after every raw change.
//
//   Optional build macro: MTR_PWM_COAST_EN
//     Adds input 'coast'. While high, both channels are held in DEAD_T with
//     the dead counter at DEAD-1 (all four PWMs low from the next clk). On
//     release each channel waits a full dead interval before following raw.
//     Counter and duty shadowing keep running during coast.
// -----------------------------------------------------------------------------
module mtr_pwm_drv #(
  parameter int DEAD  = 32,   // non-overlap cycles, legal 1..255
  parameter int PWM_W = 11    // counter / duty width
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef MTR_PWM_COAST_EN
  input  logic                    coast,
`endif
  input  logic signed [PWM_W-1:0] lft_spd,
  input  logic signed [PWM_W-1:0] rght_spd,
  output logic                    lftPWM1,
  output logic                    lftPWM2,
  output logic                    rghtPWM1,
  output logic                    rghtPWM2,
  output logic                    duty_upd
);

  // Channel index 0 = left, 1 = right.
  localparam int NCH = 2;

  // Dead counter is 8 bits wide to cover the full legal DEAD range.
  localparam logic [7:0]       DEAD_LD    = 8'(DEAD - 1);
  localparam logic [PWM_W-1:0] CNT_LAST   = '1;
  localparam logic [PWM_W-1:0] CNT_PRE    = {{(PWM_W-1){1'b1}}, 1'b0};
  localparam logic [PWM_W-1:0] DUTY_RESET = {1'b1, {(PWM_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_FWD,     // PWM1=1, PWM2=0
    ST_REV,     // PWM1=0, PWM2=1
    ST_DEAD     // both legs off
  } state_t;

  // ---------------------------------------------------------------------------
  // Signals
  // ---------------------------------------------------------------------------
  logic [PWM_W-1:0] r_cnt;
  logic             w_wrap;
  logic             r_duty_upd;

  logic [PWM_W-1:0] w_duty_new [NCH];
  logic [PWM_W-1:0] r_duty     [NCH];

  logic [NCH-1:0]   r_raw;
  logic [NCH-1:0]   r_raw_prev;
  logic [NCH-1:0]   w_raw_chg;

  state_t           r_state     [NCH];
  state_t           w_state_nxt [NCH];
  logic [7:0]       r_dcnt      [NCH];
  logic [7:0]       w_dcnt_nxt  [NCH];

  logic [NCH-1:0]   r_pwm1;
  logic [NCH-1:0]   r_pwm2;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  assign w_wrap = (r_cnt == CNT_LAST);

  // Adding half-scale to a two's-complement value only flips its MSB, so the
  // result spans 0..2^PWM_W-1 with no overflow.
  assign w_duty_new[0] = {~lft_spd[PWM_W-1],  lft_spd[PWM_W-2:0]};
  assign w_duty_new[1] = {~rght_spd[PWM_W-1], rght_spd[PWM_W-2:0]};

  assign w_raw_chg = r_raw ^ r_raw_prev;

  // Free-running period counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values, independent of block ordering.
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Shadowed duty registers, loaded only at the period wrap so a mid-period
  // command change cannot produce a glitch pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the duty array is small control state and must power up at
      // 50%, so it is reset explicitly, unlike a RAM-style storage array.
      for (int i = 0; i < NCH; i++) r_duty[i] <= DUTY_RESET;
    end else if (w_wrap) begin
      for (int i = 0; i < NCH; i++) r_duty[i] <= w_duty_new[i];
    end
  end

  // duty_upd is decoded one cycle early so the registered pulse coincides
  // with the cycle the counter sits at its top value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty_upd <= 1'b0;
    end else begin
      r_duty_upd <= (r_cnt == CNT_PRE);
    end
  end

  // Registered raw compare and its one-cycle history for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_raw      <= '1;
      r_raw_prev <= '1;
    end else begin
      for (int i = 0; i < NCH; i++) r_raw[i] <= (r_cnt < r_duty[i]);
      r_raw_prev <= r_raw;
    end
  end

  // Non-overlap FSM state register and dead counter, per channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        r_state[i] <= ST_FWD;
        r_dcnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_dcnt[i]  <= w_dcnt_nxt[i];
      end
    end
  end

  // Next-state logic: any raw change (re)starts the dead interval; once it
  // expires the channel follows the current raw level.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      w_state_nxt[i] = r_state[i];
      w_dcnt_nxt[i]  = r_dcnt[i];

`ifdef MTR_PWM_COAST_EN
      if (coast) begin
        w_state_nxt[i] = ST_DEAD;
        w_dcnt_nxt[i]  = DEAD_LD;
      end else
`endif
      if (w_raw_chg[i]) begin
        w_state_nxt[i] = ST_DEAD;
        w_dcnt_nxt[i]  = DEAD_LD;
      end else if (r_state[i] == ST_DEAD) begin
        if (r_dcnt[i] == 8'd0) begin
          w_state_nxt[i] = r_raw[i] ? ST_FWD : ST_REV;
        end else begin
          w_dcnt_nxt[i] = r_dcnt[i] - 8'd1;
        end
      end
    end
  end

  // Output flops decoded from the next state, so the pins are clean
  // registered signals that track the FSM state cycle for cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm1 <= '1;
      r_pwm2 <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        r_pwm1[i] <= (w_state_nxt[i] == ST_FWD);
        r_pwm2[i] <= (w_state_nxt[i] == ST_REV);
      end
    end
  end

  assign lftPWM1  = r_pwm1[0];
  assign lftPWM2  = r_pwm2[0];
  assign rghtPWM1 = r_pwm1[1];
  assign rghtPWM2 = r_pwm2[1];
  assign duty_upd = r_duty_upd;

endmodule
